// File: rtl/rgb_to_hsv_stream_pkg.sv
// rtl/rgb_to_hsv_stream_pkg.sv - shared encodings and helpers for the RGB to HSV converter
package hsv_pkg;

    // FSM state encoding, also exported on the State debug port
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMP   = 3'd1,
        DIV_S = 3'd2,
        DIV_H = 3'd3,
        FIX   = 3'd4,
        OUT   = 3'd5
    } state_t;

    // Dominant-channel select; tie priority is R > G > B
    localparam logic [1:0] SEL_R = 2'd0;
    localparam logic [1:0] SEL_G = 2'd1;
    localparam logic [1:0] SEL_B = 2'd2;

    // One full hue circle in sixths with frac_w fractional bits
    function automatic int unsigned hue_full(input int unsigned frac_w);
        return 32'd6 << frac_w;
    endfunction

endpackage

// File: rtl/rgb_to_hsv_stream_if.sv
// rtl/rgb_to_hsv_stream_if.sv - pixel-in / HSV-out handshake bundle
interface rgb_to_hsv_stream_if #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] R;
    logic [DATA_W-1:0] G;
    logic [DATA_W-1:0] B;
    logic              out_valid;
    logic              out_ready;
    logic [FRAC_W+2:0] H;
    logic [FRAC_W:0]   S;
    logic [DATA_W-1:0] V;

    // Pixel source and HSV consumer side
    modport master (
        output in_valid, R, G, B, out_ready,
        input  in_ready, out_valid, H, S, V
    );

    // Converter side
    modport slave (
        input  in_valid, R, G, B, out_ready,
        output in_ready, out_valid, H, S, V
    );
endinterface

// File: rtl/rgb_to_hsv_stream_seq_divider.sv
// rtl/rgb_to_hsv_stream_seq_divider.sv - fixed-latency restoring divider, quot = (num << (Q_W-1)) / den
module seq_divider #(
    parameter int NUM_W = 8,
    parameter int DEN_W = 8,
    parameter int Q_W   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quot,
    output logic             zero_div
);
    // Callers guarantee num <= den, so only the low Q_W quotient bits can be
    // set and the partial remainder starts at num >> 1. The start edge already
    // resolves the top quotient bit, so the result is ready Q_W edges after start.
    localparam int CNT_W = $clog2(Q_W) + 1;

    logic [DEN_W:0]   rem;
    logic [DEN_W-1:0] den_q;
    logic [Q_W-1:0]   q_q;
    logic [CNT_W-1:0] cnt;
    logic             zero_q;

    logic [DEN_W:0]   rem_in;
    logic             in_bit;
    logic [DEN_W-1:0] d_cur;
    logic [DEN_W:0]   sh;
    logic             ge;
    logic [DEN_W:0]   rem_nxt;

    // One restoring step: shift in the next numerator bit, subtract if it fits
    always_comb begin
        rem_in  = start ? (DEN_W+1)'(num >> 1) : rem;
        in_bit  = start ? num[0] : 1'b0;
        d_cur   = start ? den : den_q;
        sh      = (DEN_W+1)'({rem_in, in_bit});
        ge      = (sh >= {1'b0, d_cur});
        rem_nxt = ge ? (sh - {1'b0, d_cur}) : sh;
    end

    // Iteration control; the run length is the same for a zero divisor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            den_q  <= '0;
            q_q    <= '0;
            cnt    <= '0;
            zero_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem    <= rem_nxt;
                q_q    <= Q_W'(ge);
                den_q  <= den;
                zero_q <= (den == '0);
                cnt    <= CNT_W'(Q_W - 1);
                busy   <= 1'b1;
            end else if (busy) begin
                rem <= rem_nxt;
                q_q <= {q_q[Q_W-2:0], ge};
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quot     = zero_q ? '0 : q_q;
    assign zero_div = zero_q;

endmodule

// File: rtl/rgb_to_hsv_stream.sv
// rtl/rgb_to_hsv_stream.sv - streaming RGB to HSV converter with one shared sequential divider
module rgb_to_hsv_stream
    import hsv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 8
) (
    input  logic                Clk,
    input  logic                reset,
    rgb_to_hsv_stream_if.slave  pix,
    output logic [DATA_W-1:0]   Max,
    output logic [DATA_W-1:0]   Delta,
    output logic [2:0]          State
);
    localparam int Q_W = FRAC_W + 1;
    localparam int H_W = FRAC_W + 3;
    localparam logic [H_W-1:0] HUE_FULL = H_W'(hue_full(FRAC_W));

    state_t state, state_nxt;

    logic [DATA_W-1:0] r_q, g_q, b_q;
    logic [DATA_W-1:0] num_q;
    logic [1:0]        sel_q;
    logic              neg_q;
    logic [Q_W-1:0]    s_q;
    logic [Q_W-1:0]    qh_q;
    logic              hz_q;

    logic [DATA_W-1:0] mx, mn, dl, num_c;
    logic [1:0]        sel_c;
    logic              neg_c;

    logic              div_start, div_busy, div_done, div_zero;
    logic [DATA_W-1:0] div_num, div_den;
    logic [Q_W-1:0]    div_quot;

    logic [H_W-1:0]    offset, qh_ext, h_raw, h_c;

    // State register
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; each divide state lasts until the divider reports done
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pix.in_valid) state_nxt = CMP;
            CMP:     state_nxt = DIV_S;
            DIV_S:   if (div_done) state_nxt = DIV_H;
            DIV_H:   if (div_done) state_nxt = FIX;
            FIX:     state_nxt = OUT;
            OUT:     if (pix.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: handshakes and divider launches (S from CMP, H on S done)
    always_comb begin
        pix.in_ready  = reset && (state == IDLE);
        pix.out_valid = (state == OUT);
        div_start     = 1'b0;
        case (state)
            CMP:     div_start = !div_busy;
            DIV_S:   div_start = div_done && !div_busy;
            default: div_start = 1'b0;
        endcase
    end

    assign State = state;

    // Max/min, dominant channel and hue numerator from the captured pixel
    always_comb begin
        mx = r_q;
        mn = r_q;
        if (g_q > mx) mx = g_q;
        if (b_q > mx) mx = b_q;
        if (g_q < mn) mn = g_q;
        if (b_q < mn) mn = b_q;
        dl = mx - mn;
        if (r_q >= g_q && r_q >= b_q) begin
            sel_c = SEL_R;
            num_c = (g_q >= b_q) ? (g_q - b_q) : (b_q - g_q);
            neg_c = (b_q > g_q);
        end else if (g_q >= b_q) begin
            sel_c = SEL_G;
            num_c = (b_q >= r_q) ? (b_q - r_q) : (r_q - b_q);
            neg_c = (r_q > b_q);
        end else begin
            sel_c = SEL_B;
            num_c = (r_q >= g_q) ? (r_q - g_q) : (g_q - r_q);
            neg_c = (g_q > r_q);
        end
    end

    // Divider operands: Delta/Max for S straight from CMP, then num/Delta for H
    always_comb begin
        div_num = (state == CMP) ? dl : num_q;
        div_den = (state == CMP) ? mx : Delta;
    end

    seq_divider #(
        .NUM_W (DATA_W),
        .DEN_W (DATA_W),
        .Q_W   (Q_W)
    ) u_div (
        .clk      (Clk),
        .rst_n    (reset),
        .start    (div_start),
        .num      (div_num),
        .den      (div_den),
        .busy     (div_busy),
        .done     (div_done),
        .quot     (div_quot),
        .zero_div (div_zero)
    );

    // Hue assembly: sector offset plus or minus qh, wrapping a full circle to 0
    always_comb begin
        qh_ext = H_W'(qh_q);
        case (sel_q)
            SEL_G:   offset = H_W'(2) << FRAC_W;
            SEL_B:   offset = H_W'(4) << FRAC_W;
            default: offset = '0;
        endcase
        if (sel_q == SEL_R) h_raw = neg_q ? (HUE_FULL - qh_ext) : qh_ext;
        else                h_raw = neg_q ? (offset - qh_ext) : (offset + qh_ext);
        h_c = h_raw;
        if (h_raw == HUE_FULL || hz_q) h_c = '0;
    end

    // Datapath registers; visible results only change in FIX
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            num_q <= '0;
            sel_q <= SEL_R;
            neg_q <= 1'b0;
            s_q   <= '0;
            qh_q  <= '0;
            hz_q  <= 1'b0;
            Max   <= '0;
            Delta <= '0;
            pix.H <= '0;
            pix.S <= '0;
            pix.V <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pix.in_valid && pix.in_ready) begin
                        r_q <= pix.R;
                        g_q <= pix.G;
                        b_q <= pix.B;
                    end
                end
                CMP: begin
                    Max   <= mx;
                    Delta <= dl;
                    sel_q <= sel_c;
                    num_q <= num_c;
                    neg_q <= neg_c;
                end
                DIV_S: if (div_done) s_q <= div_quot;
                DIV_H: begin
                    if (div_done) begin
                        qh_q <= div_quot;
                        hz_q <= div_zero;
                    end
                end
                FIX: begin
                    pix.H <= h_c;
                    pix.S <= s_q;
                    pix.V <= Max;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_to_hsv_stream.sv
// tb/tb_rgb_to_hsv_stream.sv - scoreboard bench for rgb_to_hsv_stream
module tb_rgb_to_hsv_stream;
    localparam int DATA_W = 8;
    localparam int FRAC_W = 8;
    localparam int LAT    = 2 * FRAC_W + 4;
    localparam int ISSUE  = 2 * FRAC_W + 6;

    typedef struct {
        logic [FRAC_W+2:0] h;
        logic [FRAC_W:0]   s;
        logic [DATA_W-1:0] v;
    } exp_t;

    logic              Clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] Max, Delta;
    logic [2:0]        State;

    rgb_to_hsv_stream_if #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) pix ();

    rgb_to_hsv_stream #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
        .Clk   (Clk),
        .reset (reset),
        .pix   (pix),
        .Max   (Max),
        .Delta (Delta),
        .State (State)
    );

    always #5 Clk = ~Clk;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   prev_accept = 0;
    int   outputs = 0;
    bit   prev_ov = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: latency on each rising out_valid, scoreboard pop on each transfer
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (reset) begin
                if (pix.in_valid && pix.in_ready) begin
                    prev_accept = accept_cyc;
                    accept_cyc  = cyc + 1;
                end
                if (pix.out_valid && !prev_ov)
                    check("latency", cyc - accept_cyc, LAT);
                if (pix.out_valid && pix.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got H=%0d S=%0d V=%0d with empty scoreboard",
                                 pix.H, pix.S, pix.V);
                    end else begin
                        e = sb.pop_front();
                        check("H", pix.H, e.h);
                        check("S", pix.S, e.s);
                        check("V", pix.V, e.v);
                        outputs++;
                    end
                end
            end
            prev_ov = pix.out_valid;
        end
    end

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [10:0] h, input logic [8:0] s, input logic [7:0] v);
        exp_t e;
        bit   ok = 1'b0;
        @(posedge Clk); #1;
        pix.R = r;
        pix.G = g;
        pix.B = b;
        pix.in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge Clk);
            if (pix.in_ready) ok = 1'b1;
        end
        if (ok) begin
            e.h = h;
            e.s = s;
            e.v = v;
            sb.push_back(e);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
        @(posedge Clk); #1;
        pix.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge Clk);
            if (sb.size() == 0 && pix.in_ready) ok = 1'b1;
        end
        check("drain", ok, 1);
    endtask

    initial begin
        bit seen;
        pix.in_valid  = 1'b0;
        pix.R         = '0;
        pix.G         = '0;
        pix.B         = '0;
        pix.out_ready = 1'b1;
        #2;
        check("rst_state", State, 0);
        check("rst_in_ready", pix.in_ready, 0);
        check("rst_out_valid", pix.out_valid, 0);
        check("rst_H", pix.H, 0);
        check("rst_S", pix.S, 0);
        check("rst_V", pix.V, 0);
        check("rst_max", Max, 0);
        check("rst_delta", Delta, 0);
        @(negedge Clk);
        reset = 1'b1;

        // Directed vectors with hand-computed H, S, V
        send(8'd255, 8'd0,   8'd0,   11'd0,    9'd256, 8'd255);
        send(8'd0,   8'd255, 8'd0,   11'd512,  9'd256, 8'd255);
        check("issue_interval", accept_cyc - prev_accept, ISSUE);
        send(8'd0,   8'd0,   8'd255, 11'd1024, 9'd256, 8'd255);
        send(8'd128, 8'd128, 8'd128, 11'd0,    9'd0,   8'd128);
        send(8'd0,   8'd0,   8'd0,   11'd0,    9'd0,   8'd0);
        send(8'd255, 8'd0,   8'd255, 11'd1280, 9'd256, 8'd255);
        drain();

        // Backpressure: result held, input ignored while in OUT
        @(posedge Clk); #1;
        pix.out_ready = 1'b0;
        send(8'd255, 8'd128, 8'd0, 11'd128, 9'd256, 8'd255);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge Clk);
            if (pix.out_valid) seen = 1'b1;
        end
        check("bp_out_valid_seen", seen, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            pix.R = 8'd0;
            pix.G = 8'd0;
            pix.B = 8'd255;
            pix.in_valid = i[0];
            @(negedge Clk);
            check("bp_out_valid", pix.out_valid, 1);
            check("bp_in_ready", pix.in_ready, 0);
            check("bp_H", pix.H, 128);
            check("bp_S", pix.S, 256);
            check("bp_V", pix.V, 255);
        end
        @(posedge Clk); #1;
        pix.in_valid  = 1'b0;
        pix.out_ready = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check("bp_release_in_ready", pix.in_ready, 1);
        check("bp_release_out_valid", pix.out_valid, 0);
        check("bp_max", Max, 255);
        check("bp_delta", Delta, 255);
        check("bp_H_kept", pix.H, 128);
        drain();

        // Reset in the middle of the hue division
        send(8'd0, 8'd0, 8'd255, 11'd1024, 9'd256, 8'd255);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge Clk);
            if (State == 3'd3) seen = 1'b1;
        end
        check("reach_div_h", seen, 1);
        reset = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_state", State, 0);
        check("mid_rst_out_valid", pix.out_valid, 0);
        check("mid_rst_in_ready", pix.in_ready, 0);
        check("mid_rst_H", pix.H, 0);
        check("mid_rst_S", pix.S, 0);
        check("mid_rst_V", pix.V, 0);
        check("mid_rst_max", Max, 0);
        check("mid_rst_delta", Delta, 0);
        repeat (3) @(negedge Clk);
        reset = 1'b1;
        send(8'd0, 8'd255, 8'd0, 11'd512, 9'd256, 8'd255);
        drain();
        check("output_count", outputs, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb_to_hsv_stream.md
Name: rgb_to_hsv_stream

Overview:
Parametrised successor of the pixel-colour converter. Takes one integer RGB pixel per handshake and produces fixed-point H, S and integer V. It uses a max/min compare stage and a shared sequential restoring divider under a state machine. It sits between the pixel source (image buffer / bench memory) and HSV consumers, with valid/ready flow control on both sides.

Parameters:
DATA_W, 8, width of each R/G/B channel and of V
FRAC_W, 8, fractional bits of S and H; S range 0..2^FRAC_W (1.0), H in sixths-of-circle units, range 0..6*2^FRAC_W-1

Ports:
Clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  RGB pixel available
in_ready  out  1  block accepts pixel
R  in  DATA_W  red
G  in  DATA_W  green
B  in  DATA_W  blue
out_valid  out  1  HSV result valid
out_ready  in  1  consumer accepts result
H  out  FRAC_W+3  hue, unsigned fixed-point, sixths
S  out  FRAC_W+1  saturation, 2^FRAC_W = 1.0
V  out  DATA_W  value = max(R,G,B)
Max  out  DATA_W  debug: latched max
Delta  out  DATA_W  debug: latched max-min
State  out  3  debug: current FSM state encoding

Behaviour:
- Clk is the only clock. reset is asynchronous and active-low. While reset=0: state IDLE; in_ready=0; out_valid=0; H, S, V, Max and Delta=0.
- FSM states (State encoding): IDLE=0, CMP=1, DIV_S=2, DIV_H=3, FIX=4, OUT=5.
- IDLE: in_ready=1. On in_valid&in_ready, latch R,G,B and go to CMP. in_ready=0 in all other states, so there is no input overlap.
- CMP (1 cycle):
  - Max=max, Min=min, Delta=Max-Min.
  - Select the dominant channel with tie priority R > G > B.
  - num = |G-B| (R dominant), |B-R| (G dominant), |R-G| (B dominant).
  - Latch sign neg = (second term > first term).
- DIV_S (exactly FRAC_W+1 cycles): restoring division q=(Delta<<FRAC_W)/Max, truncating. If Max=0, S=0.
- DIV_H (exactly FRAC_W+1 cycles): same divider, qh=(num<<FRAC_W)/Delta. If Delta=0, qh=0.
- The divider is reused for both divisions. The cycle count is fixed even for zero divisors; the result is forced to 0 in that case.
- FIX (1 cycle): base = 0 (R), 2 (G), 4 (B); sector offset = base*2^FRAC_W.
  - R dominant: H = neg ? 6*2^FRAC_W - qh : qh.
  - G/B dominant: H = offset + (neg ? -qh : +qh).
  - If H == 6*2^FRAC_W, wrap H to 0.
  - If Delta=0, H=0.
  - V=Max.
- OUT: out_valid=1. H, S and V are held stable while out_ready=0. On out_valid&out_ready go to IDLE; out_valid drops the next cycle.
- Latency: out_valid rises exactly 2*FRAC_W+4 cycles after the accepting edge (12+8=20 for FRAC_W=8).
- Minimum issue interval: 2*FRAC_W+6 cycles with out_ready held 1.
- Widths: all intermediate arithmetic is unsigned. Divider remainder is DATA_W+1 bits; quotient is FRAC_W+1 bits. Quotient never exceeds 2^FRAC_W because num ≤ Delta ≤ Max.
- Reset asserted mid-operation: immediate return to reset values. The partial result is discarded and never emitted.
- in_valid asserted outside IDLE: ignored, no capture. Upstream must hold the pixel until in_ready.
- H, S and V keep their last values after the OUT handshake until the next FIX.

Decomposition:
- Package hsv_pkg: state encoding constants (IDLE..OUT), channel-select encoding (SEL_R/G/B), and the HUE_FULL=6<<FRAC_W helper.
- One sub-module: seq_divider (start/busy/done restoring divider, parameterised numerator/denominator widths, zero-divisor flag). It is instantiated once and shared by DIV_S and DIV_H.

Test Plan:
All cases use DATA_W=8, FRAC_W=8.
- (255,0,0) -> H=0, S=256, V=255. out_valid exactly 20 cycles after the accept edge.
- (0,255,0) -> H=512, S=256. (0,0,255) -> H=1024, S=256, V=255.
- (128,128,128) -> H=0, S=0, V=128. (0,0,0) -> H=0, S=0, V=0. No divide fault, same latency.
- (255,0,255) R/B tie, R wins -> H=1280, S=256. (255,128,0) -> H=128, S=256, V=255.
- Backpressure: hold out_ready=0 for 10 cycles -> H, S and V stable, out_valid=1, in_ready=0, and in_valid pulses ignored. Release -> one transfer, then in_ready=1 the cycle after.
- Drop reset to 0 while in DIV_H -> all outputs 0 immediately, State=0. After release, the next pixel (0,255,0) produces only its own correct result.
